fp_multiplier_param: RTL



---
 rtl/fp_mul_pkg.sv | 49 ++++
 rtl/fp_round_decide.sv | 28 ++
 rtl/fp_multiplier_param.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and format helpers for the parametrised floating-point multiplier.
// Pattern helpers return 64-bit images; callers size-cast them to their word width.
package fp_mul_pkg;

    typedef enum logic [3:0] {
        ST_GET,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORM_A,
        ST_NORM_B,
        ST_MUL0,
        ST_MUL1,
        ST_NORM_1,
        ST_NORM_2,
        ST_ROUND,
        ST_PACK,
        ST_PUT
    } state_e;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: sign set, exponent all ones, fraction MSB only.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (exp_w + man_w)) | (64'd1 << (man_w - 1));
    endfunction

    // Largest finite magnitude: exponent all ones except LSB, fraction all ones.
    function automatic logic [63:0] fp_max(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + man_w)) - 64'd1) & ~(64'd1 << man_w);
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Rounding increment decision from sign, result LSB and guard/round/sticky bits.
module fp_round_decide
    import fp_mul_pkg::*;
(
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_r,
    input  logic       i_s,
    input  logic [1:0] i_rm,
    output logic       o_inc
);

    logic w_any;
    assign w_any = i_g | i_r | i_s;

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE:  o_inc = i_g & (i_r | i_s | i_lsb);
            RM_RTZ:  o_inc = 1'b0;
            RM_RUP:  o_inc = w_any & ~i_sign;
            RM_RDN:  o_inc = w_any & i_sign;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-754 multiplier with run-time rounding mode and exception flags,
// using a strobe/ack handshake on both operand and result sides.
module fp_multiplier_param
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     input_a,
    input  logic [EXP_W+MAN_W:0]     input_b,
    input  logic [1:0]               input_rm,
    input  logic                     input_stb,
    output logic                     input_ack,
    output logic [EXP_W+MAN_W:0]     output_z,
    output logic [3:0]               output_flags,
    output logic                     output_z_stb,
    input  logic                     output_z_ack
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int P  = 2 * N;
    localparam int EW = EXP_W + 2;
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN   = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [EXP_W-1:0]     BIAS_F = EXP_W'(BIAS);
    localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0]         INF_MAG = (W-1)'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-2:0]         MAX_MAG = (W-1)'(fp_max(EXP_W, MAN_W));

    state_e                 r_state;
    logic [W-1:0]           r_a, r_b;
    logic [1:0]             r_rm;
    logic signed [EW-1:0]   r_a_e, r_b_e, r_z_e;
    logic [N-1:0]           r_a_m, r_b_m, r_z_m;
    logic [P-1:0]           r_prod;
    logic                   r_z_s, r_g, r_r, r_s, r_tiny, r_inx;
    logic                   r_input_ack, r_z_stb;
    logic [W-1:0]           r_out_z;
    logic [3:0]             r_flags;

    // Operand field decode (raw captured words)
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic w_a_exp_ones, w_b_exp_ones, w_a_exp_zero, w_b_exp_zero;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic w_inf_zero, w_sign;

    assign w_a_exp      = r_a[W-2:MAN_W];
    assign w_b_exp      = r_b[W-2:MAN_W];
    assign w_a_frac     = r_a[MAN_W-1:0];
    assign w_b_frac     = r_b[MAN_W-1:0];
    assign w_a_exp_ones = &w_a_exp;
    assign w_b_exp_ones = &w_b_exp;
    assign w_a_exp_zero = ~|w_a_exp;
    assign w_b_exp_zero = ~|w_b_exp;
    assign w_a_nan      = w_a_exp_ones & (|w_a_frac);
    assign w_b_nan      = w_b_exp_ones & (|w_b_frac);
    assign w_a_snan     = w_a_nan & ~w_a_frac[MAN_W-1];
    assign w_b_snan     = w_b_nan & ~w_b_frac[MAN_W-1];
    assign w_a_inf      = w_a_exp_ones & ~(|w_a_frac);
    assign w_b_inf      = w_b_exp_ones & ~(|w_b_frac);
    assign w_a_zero     = w_a_exp_zero & ~(|w_a_frac);
    assign w_b_zero     = w_b_exp_zero & ~(|w_b_frac);
    assign w_inf_zero   = (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
    assign w_sign       = r_a[W-1] ^ r_b[W-1];

    logic           w_spec;
    logic [W-1:0]   w_spec_z;
    logic [3:0]     w_spec_flags;

    always_comb begin
        w_spec       = 1'b1;
        w_spec_z     = '0;
        w_spec_flags = '0;
        if (w_a_nan | w_b_nan | w_inf_zero) begin
            w_spec_z = QNAN;
            w_spec_flags[FLAG_INV] = w_a_snan | w_b_snan | w_inf_zero;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_z = {w_sign, INF_MAG};
        end else if (w_a_zero | w_b_zero) begin
            w_spec_z = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // Denormalising right shift done as one barrel step; the bits that fall off
    // are folded into sticky exactly as a bit-serial shift would.
    logic [EW-1:0]  w_sh;
    logic [N+1:0]   w_ext, w_ext_sh;
    logic           w_lost;

    assign w_sh     = EMIN - r_z_e;
    assign w_ext    = {r_z_m, r_g, r_r};
    assign w_ext_sh = w_ext >> w_sh;
    assign w_lost   = |(w_ext & ~({(N+2){1'b1}} << w_sh));

    logic           w_inc;
    logic [N:0]     w_m_rnd;

    fp_round_decide u_round (
        .i_sign (r_z_s),
        .i_lsb  (r_z_m[0]),
        .i_g    (r_g),
        .i_r    (r_r),
        .i_s    (r_s),
        .i_rm   (r_rm),
        .o_inc  (w_inc)
    );

    assign w_m_rnd = {1'b0, r_z_m} + {{N{1'b0}}, w_inc};

    logic               w_ovf;
    logic [EXP_W-1:0]   w_pack_exp;
    logic [W-1:0]       w_pack_z;
    logic [3:0]         w_pack_flags;

    assign w_ovf      = (r_z_e > BIAS_E);
    // A cleared hidden bit means the result sits in the denormal range.
    assign w_pack_exp = r_z_m[MAN_W] ? (r_z_e[EXP_W-1:0] + BIAS_F) : {EXP_W{1'b0}};

    always_comb begin
        w_pack_z     = {r_z_s, w_pack_exp, r_z_m[MAN_W-1:0]};
        w_pack_flags = '0;
        if (w_ovf) begin
            w_pack_flags[FLAG_OVF] = 1'b1;
            w_pack_flags[FLAG_INX] = 1'b1;
            case (r_rm)
                RM_RNE:  w_pack_z = {r_z_s, INF_MAG};
                RM_RTZ:  w_pack_z = {r_z_s, MAX_MAG};
                RM_RUP:  w_pack_z = {r_z_s, r_z_s ? MAX_MAG : INF_MAG};
                RM_RDN:  w_pack_z = {r_z_s, r_z_s ? INF_MAG : MAX_MAG};
                default: w_pack_z = {r_z_s, INF_MAG};
            endcase
        end else begin
            w_pack_flags[FLAG_UNF] = r_tiny & r_inx;
            w_pack_flags[FLAG_INX] = r_inx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_GET;
            r_input_ack <= 1'b0;
            r_z_stb     <= 1'b0;
            r_out_z     <= '0;
            r_flags     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rm        <= RM_RNE;
            r_a_e       <= '0;
            r_b_e       <= '0;
            r_z_e       <= '0;
            r_a_m       <= '0;
            r_b_m       <= '0;
            r_z_m       <= '0;
            r_prod      <= '0;
            r_z_s       <= 1'b0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_tiny      <= 1'b0;
            r_inx       <= 1'b0;
        end else begin
            case (r_state)
                ST_GET: begin
                    if (r_input_ack && input_stb) begin
                        r_a         <= input_a;
                        r_b         <= input_b;
                        r_rm        <= input_rm;
                        r_input_ack <= 1'b0;
                        r_state     <= ST_UNPACK;
                    end else begin
                        r_input_ack <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    r_a_e   <= w_a_exp_zero ? EMIN : ($signed({2'b00, w_a_exp}) - BIAS_E);
                    r_b_e   <= w_b_exp_zero ? EMIN : ($signed({2'b00, w_b_exp}) - BIAS_E);
                    r_a_m   <= {~w_a_exp_zero, w_a_frac};
                    r_b_m   <= {~w_b_exp_zero, w_b_frac};
                    r_state <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    r_z_s <= w_sign;
                    if (w_spec) begin
                        r_out_z <= w_spec_z;
                        r_flags <= w_spec_flags;
                        r_z_stb <= 1'b1;
                        r_state <= ST_PUT;
                    end else begin
                        r_state <= ST_NORM_A;
                    end
                end
                ST_NORM_A: begin
                    if (!r_a_m[MAN_W]) begin
                        r_a_m <= r_a_m << 1;
                        r_a_e <= r_a_e - ONE_E;
                    end else begin
                        r_state <= ST_NORM_B;
                    end
                end
                ST_NORM_B: begin
                    if (!r_b_m[MAN_W]) begin
                        r_b_m <= r_b_m << 1;
                        r_b_e <= r_b_e - ONE_E;
                    end else begin
                        r_state <= ST_MUL0;
                    end
                end
                ST_MUL0: begin
                    r_prod  <= P'(r_a_m) * P'(r_b_m);
                    r_z_e   <= r_a_e + r_b_e + ONE_E;
                    r_state <= ST_MUL1;
                end
                ST_MUL1: begin
                    r_z_m   <= r_prod[P-1:N];
                    r_g     <= r_prod[N-1];
                    r_r     <= r_prod[N-2];
                    r_s     <= |r_prod[N-3:0];
                    r_state <= ST_NORM_1;
                end
                ST_NORM_1: begin
                    // Normalised operands leave the product MSB at most one place low.
                    if (!r_z_m[MAN_W]) begin
                        r_z_m <= {r_z_m[N-2:0], r_g};
                        r_g   <= r_r;
                        r_r   <= 1'b0;
                        r_z_e <= r_z_e - ONE_E;
                    end
                    r_state <= ST_NORM_2;
                end
                ST_NORM_2: begin
                    if (r_z_e < EMIN) begin
                        r_z_m  <= w_ext_sh[N+1:2];
                        r_g    <= w_ext_sh[1];
                        r_r    <= w_ext_sh[0];
                        r_s    <= r_s | w_lost;
                        r_z_e  <= EMIN;
                        r_tiny <= 1'b1;
                    end else begin
                        r_tiny <= 1'b0;
                    end
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_inx <= r_g | r_r | r_s;
                    if (w_m_rnd[N]) begin
                        r_z_m <= w_m_rnd[N:1];
                        r_z_e <= r_z_e + ONE_E;
                    end else begin
                        r_z_m <= w_m_rnd[N-1:0];
                    end
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    r_out_z <= w_pack_z;
                    r_flags <= w_pack_flags;
                    r_z_stb <= 1'b1;
                    r_state <= ST_PUT;
                end
                ST_PUT: begin
                    if (output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_state <= ST_GET;
                    end
                end
                default: r_state <= ST_GET;
            endcase
        end
    end

    assign input_ack    = r_input_ack;
    assign output_z     = r_out_z;
    assign output_flags = r_flags;
    assign output_z_stb = r_z_stb;

endmodule
